// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter that time-shares one combinational ALU among N_REQ requesters.
// Accept-to-response latency is 2 cycles; resp_ready low holds the response and blocks new grants.
module alu_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 32,
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_i1,
  input  logic [N_REQ*W-1:0] req_i2,
  input  logic [N_REQ*3-1:0] req_sel,
  output logic [W-1:0]       alu_i1,
  output logic [W-1:0]       alu_i2,
  output logic [2:0]         alu_sel,
  output logic [3:0]         alu_cin,
  input  logic [W-1:0]       alu_out,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IW-1:0]      resp_id,
  output logic [W-1:0]       resp_data,
  output logic               resp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0]  SEL_ILLEGAL = 3'b011;
  localparam logic [IW:0] NREQ_W      = (IW+1)'(N_REQ);

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW:0]   cand;
  logic          found;
  logic          accept;

  // Walk upward from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req_valid[cand[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  assign accept  = (state_q == IDLE) && found;
  assign alu_cin = 4'b0;

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_ready[k] = accept && (gnt_idx == IW'(k));
    end
  end

  always_comb begin
    state_d    = state_q;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      alu_i1    <= '0;
      alu_i2    <= '0;
      alu_sel   <= '0;
      resp_id   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        alu_i1  <= req_i1[gnt_idx*W +: W];
        alu_i2  <= req_i2[gnt_idx*W +: W];
        alu_sel <= req_sel[gnt_idx*3 +: 3];
        resp_id <= gnt_idx;
        rr_ptr  <= (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + IW'(1);
      end
      // The illegal select code returns a zero result flagged as an error.
      if (state_q == EXEC) begin
        if (alu_sel == SEL_ILLEGAL) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end else begin
          resp_data <= alu_out;
          resp_err  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed and random ops against a queue/array reference model.
module tb_alu_rr_scheduler;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_i1;
  logic [N*W-1:0] req_i2;
  logic [N*3-1:0] req_sel;
  logic [W-1:0]   alu_i1, alu_i2, alu_out;
  logic [2:0]     alu_sel;
  logic [3:0]     alu_cin;
  logic           resp_valid, resp_ready, resp_err;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_data;

  always #5 clk = ~clk;

  // Stand-in ALU; code 3 deliberately yields a non-zero value so the error path is visible.
  function automatic logic [31:0] alu_fn(input logic [2:0] sel, input logic [31:0] x, input logic [31:0] y);
    case (sel)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x + y;
      3'd3: return x * y;
      3'd4: return x ^ y;
      3'd5: return x - y;
      3'd6: return ~(x & y);
      default: return x << y[4:0];
    endcase
  endfunction

  assign alu_out = alu_fn(alu_sel, alu_i1, alu_i2);

  alu_rr_scheduler #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_i1(req_i1), .req_i2(req_i2), .req_sel(req_sel),
    .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic        v [N];
  logic [31:0] a [N];
  logic [31:0] b [N];
  logic [2:0]  s [N];
  int          ptr;
  logic [1:0]  last_id;
  logic [31:0] last_data;
  logic        last_err;
  int          order [5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k]       = v[k];
      req_i1[k*W +: W]   = a[k];
      req_i2[k*W +: W]   = b[k];
      req_sel[k*3 +: 3]  = s[k];
    end
  endtask

  task automatic set_op(input int k, input logic [31:0] x, input logic [31:0] y, input logic [2:0] sel);
    v[k] = 1'b1; a[k] = x; b[k] = y; s[k] = sel;
  endtask

  task automatic new_op(input int k);
    set_op(k, $urandom, $urandom, 3'($urandom_range(0, 7)));
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) begin
      v[k] = 1'b0; a[k] = '0; b[k] = '0; s[k] = '0;
    end
  endtask

  function automatic int model_grant();
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_result(input logic [2:0] sel, input logic [31:0] x, input logic [31:0] y);
    return (sel == 3'b011) ? 32'h0 : alu_fn(sel, x, y);
  endfunction

  // One IDLE decision: checks grant, EXEC, RESP (held for 'hold' cycles) and the single handshake.
  task automatic serve(input int hold, input bit refill);
    int g;
    logic [N-1:0] exp_rdy;
    logic [31:0] ea, eb, ed;
    logic [2:0] es;
    drive();
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g < 0) begin
      check("idle_ready", req_ready, exp_rdy);
      @(posedge clk); @(negedge clk);
      return;
    end
    exp_rdy[g] = 1'b1;
    check("grant", req_ready, exp_rdy);
    ea = a[g]; eb = b[g]; es = s[g];
    ed = model_result(es, ea, eb);
    ptr = (g + 1) % N;
    @(posedge clk); @(negedge clk);
    if (refill) new_op(g); else v[g] = 1'b0;
    drive();
    #1;
    check("exec_valid", resp_valid, 0);
    check("exec_ready", req_ready, 0);
    check("alu_i1", alu_i1, ea);
    check("alu_i2", alu_i2, eb);
    check("alu_sel", alu_sel, es);
    @(negedge clk); #1;
    check("resp_valid", resp_valid, 1);
    check("resp_id", resp_id, g);
    check("resp_data", resp_data, ed);
    check("resp_err", resp_err, es == 3'b011);
    last_id = resp_id; last_data = resp_data; last_err = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check("bp_valid", resp_valid, 1);
      check("bp_data", resp_data, ed);
      check("bp_id", resp_id, g);
      check("bp_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check("single_resp", resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    resp_ready = 1'b0;
    clear_all();
    drive();
    ptr = 0;
    #12;
    check("rst_ready", req_ready, 0);
    check("rst_alu_i1", alu_i1, 0);
    check("rst_alu_i2", alu_i2, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_alu_cin", alu_cin, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single AND on req0, then OR/ADD on req2.
    set_op(0, 32'h10001001, 32'h00101000, 3'b000);
    serve(0, 0);
    check("and_data", last_data, 32'h00001000);
    check("and_id", last_id, 0);
    set_op(2, 32'h10001001, 32'h00101000, 3'b001);
    serve(0, 0);
    check("or_data", last_data, 32'h10101001);
    check("or_id", last_id, 2);
    set_op(2, 32'h10001001, 32'h00101000, 3'b010);
    serve(0, 0);
    check("add_data", last_data, 32'h10102001);
    check("add_id", last_id, 2);

    // Contention from reset: all requesters valid, order 0,1,2,3,0.
    @(negedge clk); rst_n = 1'b0;
    for (int k = 0; k < N; k++) new_op(k);
    ptr = 0;
    @(negedge clk); rst_n = 1'b1;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    for (int i = 0; i < 5; i++) begin
      serve(0, 1);
      check("rr_order", last_id, order[i]);
    end
    clear_all();

    // Backpressure for 5 cycles.
    new_op(3);
    serve(5, 0);

    // Illegal select, then a normal op from the same requester.
    set_op(1, 32'hDEADBEEF, 32'h00000003, 3'b011);
    serve(0, 0);
    check("ill_err", last_err, 1);
    check("ill_data", last_data, 0);
    check("ill_id", last_id, 1);
    set_op(1, 32'h10001001, 32'h00101000, 3'b010);
    serve(0, 0);
    check("post_ill_err", last_err, 0);
    check("post_ill_data", last_data, 32'h10102001);

    // Random traffic: requesters join at random, hold until served, optionally re-request.
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!v[k] && ($urandom_range(0, 1) == 1)) new_op(k);
      end
      serve($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    clear_all();
    drive();

    // Async reset in EXEC (ph=0) and in RESP (ph=1).
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      new_op(1);
      drive();
      #1;
      check("pre_rst_grant", req_ready, 4'b0010);
      @(posedge clk); @(negedge clk);
      v[1] = 1'b0;
      drive();
      if (ph == 1) begin
        @(negedge clk); #1;
        check("pre_rst_resp", resp_valid, 1);
      end
      #2 rst_n = 1'b0;
      #1;
      check("rst_drop_valid", resp_valid, 0);
      check("rst_drop_data", resp_data, 0);
      check("rst_drop_alu", alu_i1, 0);
      @(negedge clk); rst_n = 1'b1;
      ptr = 0;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk); #1;
        check("no_resp_after_rst", resp_valid, 0);
      end
      new_op(1);
      new_op(3);
      serve(0, 0);
      check("rst_first_grant", last_id, 1);
      serve(0, 0);
      check("rst_second_grant", last_id, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
